// File: rtl/umi_xbar_ingress.sv
// Purpose: per-port ingress FIFO ahead of umi_crossbar; decodes the dest port ID into a one-hot request at push time.
// Latency: 1 cycle from accept edge to request visible; strict FIFO order.
// Backpressure: umi_in_ready is registered (count_next < DEPTH); head request/payload held stable until umi_out_ready pops it.
//
// Ports:
//   clk, nreset                        clock, async active-low reset
//   umi_in_valid/ready/cmd/dstaddr/    upstream UMI packet interface
//     srcaddr/data
//   umi_out_request[N]                 one-hot request to crossbar, zero when empty
//   umi_out_ready                      crossbar grant/ready for this port
//   umi_out_cmd/dstaddr/srcaddr/data   head-entry payload (valid only while request != 0)
//   decode_err                         one-cycle pulse per accepted packet whose ID >= N
module umi_xbar_ingress #(
    parameter int N        = 4,
    parameter int CW       = 32,
    parameter int AW       = 64,
    parameter int DW       = 512,
    parameter int DEPTH    = 4,
    parameter int IDOFFSET = 40,
    parameter int IDW      = 16,
    parameter int DEFPORT  = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    output logic          umi_in_ready,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic [N-1:0]  umi_out_request,
    input  logic          umi_out_ready,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    output logic          decode_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PW + 1;

    logic [CW-1:0] cmd_mem [DEPTH];
    logic [AW-1:0] dst_mem [DEPTH];
    logic [AW-1:0] src_mem [DEPTH];
    logic [DW-1:0] data_mem[DEPTH];
    logic [N-1:0]  req_mem [DEPTH];

    logic [PW-1:0]   wrptr, rdptr;
    logic [CNTW-1:0] count, count_next;
    logic            push, pop;
    logic [IDW-1:0]  id;
    logic [N-1:0]    req_dec;
    logic            id_bad;

    assign push = umi_in_valid & umi_in_ready;
    assign pop  = (count != '0) & umi_out_ready;

    assign count_next = count + CNTW'(push) - CNTW'(pop);

    // Destination decode; out-of-range IDs fall back to DEFPORT and flag an error.
    assign id = umi_in_dstaddr[IDOFFSET +: IDW];

    always_comb begin
        req_dec = '0;
        id_bad  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (id == IDW'(i)) begin
                req_dec[i] = 1'b1;
                id_bad     = 1'b0;
            end
        end
        if (id_bad) begin
            req_dec[DEFPORT] = 1'b1;
        end
    end

    // Control state, reset asynchronously so a mid-operation reset discards everything.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wrptr        <= '0;
            rdptr        <= '0;
            count        <= '0;
            umi_in_ready <= 1'b0;
            decode_err   <= 1'b0;
        end else begin
            if (push) wrptr <= wrptr + PW'(1);
            if (pop)  rdptr <= rdptr + PW'(1);
            count        <= count_next;
            umi_in_ready <= (count_next < CNTW'(DEPTH));
            decode_err   <= push & id_bad;
        end
    end

    // Storage is not reset; request output is gated by count instead.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wrptr]  <= umi_in_cmd;
            dst_mem[wrptr]  <= umi_in_dstaddr;
            src_mem[wrptr]  <= umi_in_srcaddr;
            data_mem[wrptr] <= umi_in_data;
            req_mem[wrptr]  <= req_dec;
        end
    end

    assign umi_out_request = (count != '0) ? req_mem[rdptr] : '0;
    assign umi_out_cmd     = cmd_mem[rdptr];
    assign umi_out_dstaddr = dst_mem[rdptr];
    assign umi_out_srcaddr = src_mem[rdptr];
    assign umi_out_data    = data_mem[rdptr];

endmodule

// File: tb/tb_umi_xbar_ingress.sv
// Purpose: directed self-checking bench for umi_xbar_ingress (N=4, DEPTH=4).
// Latency: expects request one cycle after accept, in_ready one cycle after first pop from full.
// Backpressure: exercises full FIFO with umi_out_ready low, then drains.
module tb_umi_xbar_ingress;

    localparam int N = 4, CW = 32, AW = 64, DW = 512;

    logic          clk = 1'b0;
    logic          nreset;
    logic          umi_in_valid;
    logic          umi_in_ready;
    logic [CW-1:0] umi_in_cmd;
    logic [AW-1:0] umi_in_dstaddr;
    logic [AW-1:0] umi_in_srcaddr;
    logic [DW-1:0] umi_in_data;
    logic [N-1:0]  umi_out_request;
    logic          umi_out_ready;
    logic [CW-1:0] umi_out_cmd;
    logic [AW-1:0] umi_out_dstaddr;
    logic [AW-1:0] umi_out_srcaddr;
    logic [DW-1:0] umi_out_data;
    logic          decode_err;

    int tests_run = 0;
    int tests_failed = 0;

    umi_xbar_ingress #(
        .N(4), .CW(CW), .AW(AW), .DW(DW), .DEPTH(4),
        .IDOFFSET(40), .IDW(16), .DEFPORT(0)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .umi_in_valid    (umi_in_valid),
        .umi_in_ready    (umi_in_ready),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_out_request (umi_out_request),
        .umi_out_ready   (umi_out_ready),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .decode_err      (decode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mkaddr(input logic [15:0] id);
        return {8'h00, id, 40'h00_0000_1000};
    endfunction

    task automatic drive(input logic [15:0] id, input logic [63:0] dat);
        umi_in_valid   = 1'b1;
        umi_in_dstaddr = mkaddr(id);
        umi_in_data    = DW'(dat);
    endtask

    initial begin
        nreset         = 1'b0;
        umi_in_valid   = 1'b0;
        umi_in_cmd     = 32'h0000_0005;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = 64'h1234;
        umi_in_data    = '0;
        umi_out_ready  = 1'b0;

        // 1. Reset
        repeat (5) tick();
        check("rst_in_ready", 64'(umi_in_ready), 64'd0);
        check("rst_request", 64'(umi_out_request), 64'd0);
        check("rst_decode_err", 64'(decode_err), 64'd0);
        nreset = 1'b1;
        check("rst_rel_in_ready_pre", 64'(umi_in_ready), 64'd0);
        tick();
        check("rst_rel_in_ready", 64'(umi_in_ready), 64'd1);

        // 2. Single packet to port 2 with immediate pop
        umi_out_ready  = 1'b1;
        umi_in_valid   = 1'b1;
        umi_in_dstaddr = 64'h0000_0200_0000_1000;
        umi_in_data    = DW'(64'hA5);
        tick();
        umi_in_valid = 1'b0;
        check("single_request", 64'(umi_out_request), 64'h4);
        check("single_data", umi_out_data[63:0], 64'hA5);
        check("single_dstaddr", umi_out_dstaddr, 64'h0000_0200_0000_1000);
        tick();
        check("single_popped", 64'(umi_out_request), 64'h0);

        // 3. Fill to full with out_ready low, then drain
        umi_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(16'(i), 64'(16 + i));
            tick();
            check("fill_request", 64'(umi_out_request), 64'h1);
        end
        umi_in_valid = 1'b0;
        check("full_in_ready", 64'(umi_in_ready), 64'd0);
        tick();
        check("full_hold_request", 64'(umi_out_request), 64'h1);
        check("full_hold_data", umi_out_data[63:0], 64'd16);
        check("full_hold_in_ready", 64'(umi_in_ready), 64'd0);
        umi_out_ready = 1'b1;
        tick();
        check("drain_in_ready", 64'(umi_in_ready), 64'd1);
        check("drain_req1", 64'(umi_out_request), 64'h2);
        check("drain_data1", umi_out_data[63:0], 64'd17);
        tick();
        check("drain_req2", 64'(umi_out_request), 64'h4);
        tick();
        check("drain_req3", 64'(umi_out_request), 64'h8);
        check("drain_data3", umi_out_data[63:0], 64'd19);
        tick();
        check("drain_empty", 64'(umi_out_request), 64'h0);

        // 4. Out-of-range ID goes to DEFPORT with one decode_err pulse
        drive(16'd7, 64'h77);
        tick();
        umi_in_valid = 1'b0;
        check("bad_id_request", 64'(umi_out_request), 64'h1);
        check("bad_id_err", 64'(decode_err), 64'd1);
        tick();
        check("bad_id_err_clear", 64'(decode_err), 64'd0);
        drive(16'd3, 64'h33);
        tick();
        umi_in_valid = 1'b0;
        check("id3_request", 64'(umi_out_request), 64'h8);
        check("id3_no_err", 64'(decode_err), 64'd0);
        tick();
        check("id3_no_err_late", 64'(decode_err), 64'd0);

        // 5. Back-to-back stream at full rate
        umi_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(16'(i % 4), 64'(100 + i));
            tick();
            check("stream_in_ready", 64'(umi_in_ready), 64'd1);
            check("stream_request", 64'(umi_out_request), 64'(4'b0001 << (i % 4)));
            check("stream_data", umi_out_data[63:0], 64'(100 + i));
        end
        umi_in_valid = 1'b0;
        tick();
        check("stream_empty", 64'(umi_out_request), 64'h0);

        // 6. Reset mid-operation with 3 entries stored
        umi_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'd2, 64'(200 + i));
            tick();
        end
        umi_in_valid = 1'b0;
        check("pre_rst_request", 64'(umi_out_request), 64'h4);
        #2;
        nreset = 1'b0;
        #1;
        check("midrst_request", 64'(umi_out_request), 64'h0);
        check("midrst_in_ready", 64'(umi_in_ready), 64'd0);
        tick();
        tick();
        nreset = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(umi_in_ready), 64'd1);
        check("post_rst_empty", 64'(umi_out_request), 64'h0);
        drive(16'd1, 64'h1111);
        tick();
        umi_in_valid = 1'b0;
        check("post_rst_request", 64'(umi_out_request), 64'h2);
        check("post_rst_data", umi_out_data[63:0], 64'h1111);
        umi_out_ready = 1'b1;
        tick();
        check("post_rst_no_stale", 64'(umi_out_request), 64'h0);
        tick();
        check("post_rst_no_stale2", 64'(umi_out_request), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
